// File: rtl/fb_pkg.sv
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared framebuffer definitions for the scanout reader and the
//            VGA pixel unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam logic [31:0] FB_BASE_BYTE = 32'h0000_1000;
    localparam int          FB_WORDS     = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fb_word_t;

    function automatic int byte_to_word(input logic [31:0] byte_addr);
        return int'(byte_addr >> 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_skid_fifo.sv
// ============================================================================
// Module   : fb_skid_fifo
// Purpose  : Two-entry FIFO of {last, data} absorbing the RAM read latency
//            under downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_skid_fifo
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fb_word_t    push_word,
    input  logic        pop,
    output fb_word_t    head_word,
    output logic        empty,
    output logic [1:0]  count
);

    fb_word_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_word = r_mem[r_rd_ptr];
    assign empty     = (r_count == 2'd0);
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fb_reader.sv
// ============================================================================
// Module   : fb_reader
// Purpose  : Framebuffer scanout engine: reads a contiguous word block from
//            the data RAM and streams it out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_reader
    import fb_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int BASE_WORD = byte_to_word(FB_BASE_BYTE),
    parameter int LEN_WORDS = FB_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    localparam int                c_CNT_W    = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_LEN_LAST = c_CNT_W'(LEN_WORDS - 1);
    localparam logic [ADDR_W-1:0]  c_BASE     = ADDR_W'(BASE_WORD);

    fb_state_e          r_state;
    fb_state_e          w_state_nxt;
    logic [ADDR_W-1:0]  r_idx;
    logic [c_CNT_W-1:0] r_issue_cnt;
    logic [c_CNT_W-1:0] r_hs_cnt;
    logic               r_inflight;
    logic               r_inflight_last;
    logic               r_done;

    logic               w_issue;
    logic               w_pop;
    logic               w_start_ok;
    logic               w_frame_end;
    logic [2:0]         w_occupancy;
    logic [1:0]         w_fifo_count;
    logic               w_fifo_empty;
    fb_word_t           w_push_word;
    fb_word_t           w_head_word;

    assign w_pop       = out_valid && out_ready;
    assign w_push_word = '{last: r_inflight_last, data: mem_rd};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start_ok  = 1'b0;
        w_frame_end = 1'b0;
        // Words already owed to the FIFO after this cycle's pop; a new issue
        // is allowed only while that leaves room for one more.
        w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_issue = (w_occupancy < 3'd2);
                if (w_issue && (r_issue_cnt == c_LEN_LAST)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && (r_hs_cnt == c_LEN_LAST)) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_idx           <= c_BASE;
            r_issue_cnt     <= '0;
            r_hs_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_done          <= w_frame_end;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == c_LEN_LAST);
            if (w_start_ok || w_frame_end) begin
                r_idx       <= c_BASE;
                r_issue_cnt <= '0;
                r_hs_cnt    <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
                    // Hold on the final index so the address never wraps.
                    if (r_issue_cnt != c_LEN_LAST) begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                if (w_pop) begin
                    r_hs_cnt <= r_hs_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    fb_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_word (w_push_word),
        .pop       (w_pop),
        .head_word (w_head_word),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign mem_addr  = {{(30 - ADDR_W){1'b0}}, r_idx, 2'b00};
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_head_word.data;
    assign out_last  = !w_fifo_empty && w_head_word.last;

endmodule

`default_nettype wire

// File: tb/tb_fb_reader.sv
// ============================================================================
// Module   : tb_fb_reader
// Purpose  : Scoreboard bench for fb_reader (4-word and 1-word frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, start4, busy4, done4, out_valid4, out_ready4, out_last4;
    logic [31:0] mem_addr4, mem_rd4, out_data4;
    logic        rst1, start1, busy1, done1, out_valid1, out_ready1, out_last1;
    logic [31:0] mem_addr1, mem_rd1, out_data1;

    logic [31:0] ram4 [0:2047];
    logic [31:0] ram1 [0:2047];

    logic [32:0] q4[$];
    logic [32:0] q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int hs4   = 0;
    logic        prev_stall4 = 1'b0;
    logic [31:0] prev_data4  = '0;

    fb_reader #(.ADDR_W(11), .BASE_WORD(1024), .LEN_WORDS(4)) dut4 (
        .clk(clk), .reset(rst4), .start(start4), .busy(busy4), .done(done4),
        .mem_addr(mem_addr4), .mem_rd(mem_rd4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4)
    );

    fb_reader #(.ADDR_W(11), .BASE_WORD(1024), .LEN_WORDS(1)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1)
    );

    // RAM models with a 1-cycle registered read
    always @(posedge clk) begin
        mem_rd4 <= ram4[mem_addr4[12:2]];
        mem_rd1 <= ram1[mem_addr1[12:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, 4-word DUT
    always @(negedge clk) begin
        if (rst4) begin
            prev_stall4 = 1'b0;
        end else begin
            if (prev_stall4) begin
                chk("stall_valid4", {31'b0, out_valid4}, 32'd1);
                chk("stall_data4", out_data4, prev_data4);
            end
            if (busy4) begin
                int ahead;
                ahead = int'(mem_addr4[12:2]) - 1024 - hs4;
                chk("addr_ahead4", {31'b0, (ahead >= 0 && ahead <= 2)}, 32'd1);
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected4: got %h, expected no word", out_data4);
                end else begin
                    logic [32:0] e;
                    e = q4.pop_front();
                    chk("data4", out_data4, e[31:0]);
                    chk("last4", {31'b0, out_last4}, {31'b0, e[32]});
                end
                hs4++;
            end
            prev_stall4 = out_valid4 && !out_ready4;
            prev_data4  = out_data4;
        end
    end

    // Scoreboard monitor, 1-word DUT
    always @(negedge clk) begin
        if (!rst1 && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected1: got %h, expected no word", out_data1);
            end else begin
                logic [32:0] e;
                e = q1.pop_front();
                chk("data1", out_data1, e[31:0]);
                chk("last1", {31'b0, out_last1}, {31'b0, e[32]});
            end
        end
    end

    // One 4-word frame; ready pattern applies from cycle 3, extra = further start pulses
    task automatic run_frame4(input logic [15:0] pat, input int pat_len,
                              input logic [15:0] extra, input int exp_first,
                              input int exp_done, input string tag);
        int first_v, done_at, done_cnt;
        first_v  = -1;
        done_at  = -1;
        done_cnt = 0;
        for (int k = 0; k <= exp_done + 3; k++) begin
            @(posedge clk); #1;
            start4 = (k == 0) || extra[k];
            if (k == 0) begin
                q4.push_back({1'b0, 32'hA0A0A0A0});
                q4.push_back({1'b0, 32'hB1B1B1B1});
                q4.push_back({1'b0, 32'hC2C2C2C2});
                q4.push_back({1'b1, 32'hD3D3D3D3});
                hs4 = 0;
            end
            out_ready4 = (k >= 3 && (k - 3) < pat_len) ? pat[k-3] : 1'b1;
            @(negedge clk);
            if (out_valid4 && first_v < 0) first_v = k;
            if (done4) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        start4 = 1'b0;
        chk({tag, "_first_valid"}, 32'(first_v), 32'(exp_first));
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, {31'b0, busy4}, 32'd0);
        chk({tag, "_queue_left"}, 32'(q4.size()), 32'd0);
    endtask

    initial begin
        int waited, first_v, done_at, done_cnt;
        for (int i = 0; i < 2048; i++) begin
            ram4[i] = 32'hEEEE_0000 | 32'(i);
            ram1[i] = 32'hEEEE_0000 | 32'(i);
        end
        ram4[1024] = 32'hA0A0A0A0;
        ram4[1025] = 32'hB1B1B1B1;
        ram4[1026] = 32'hC2C2C2C2;
        ram4[1027] = 32'hD3D3D3D3;
        ram1[1024] = 32'h12345678;

        // Reset held two cycles with start asserted
        rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b1; start1 = 1'b1;
        out_ready4 = 1'b1; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy4}, 32'd0);
        chk("rst_valid", {31'b0, out_valid4}, 32'd0);
        chk("rst_done", {31'b0, done4}, 32'd0);
        chk("rst_addr", mem_addr4, 32'h0000_1000);
        chk("rst_addr1", mem_addr1, 32'h0000_1000);
        @(posedge clk); #1;
        rst4 = 1'b0; rst1 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", {31'b0, busy4}, 32'd0);
        chk("idle_valid", {31'b0, out_valid4}, 32'd0);
        chk("idle_addr", mem_addr4, 32'h0000_1000);

        // Streaming, no backpressure
        run_frame4(16'h0000, 0, 16'h0000, 3, 7, "stream");
        repeat (2) @(posedge clk);

        // Backpressure: ready 1,0,0,1,0,1,1 from the first valid cycle
        run_frame4(16'b0000_0000_0110_1001, 7, 16'h0000, 3, 10, "bp");
        repeat (2) @(posedge clk);

        // Start pulses at 2 and 5 (busy) and 7 (same cycle as done)
        run_frame4(16'h0000, 0, 16'h00A4, 3, 7, "rebusy");
        @(negedge clk);
        chk("rebusy_idle", {31'b0, busy4}, 32'd0);
        repeat (2) @(posedge clk);

        // Reset after the second handshake, then restart
        @(posedge clk); #1;
        start4 = 1'b1;
        q4.push_back({1'b0, 32'hA0A0A0A0});
        q4.push_back({1'b0, 32'hB1B1B1B1});
        q4.push_back({1'b0, 32'hC2C2C2C2});
        q4.push_back({1'b1, 32'hD3D3D3D3});
        hs4 = 0;
        @(posedge clk); #1;
        start4 = 1'b0;
        waited = 0;
        @(negedge clk);
        while (hs4 < 2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("midrst_reach2", {31'b0, (hs4 >= 2)}, 32'd1);
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        rst4 = 1'b1;
        q4.delete();
        @(posedge clk); #1;
        rst4 = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'b0, out_valid4}, 32'd0);
        chk("midrst_addr", mem_addr4, 32'h0000_1000);
        run_frame4(16'h0000, 0, 16'h0000, 3, 7, "restart");
        repeat (2) @(posedge clk);

        // Single-word frame
        first_v = -1; done_at = -1; done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start1 = (k == 0);
            if (k == 0) q1.push_back({1'b1, 32'h12345678});
            @(negedge clk);
            if (out_valid1 && first_v < 0) first_v = k;
            if (done1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        chk("single_first_valid", 32'(first_v), 32'd3);
        chk("single_done_cycle", 32'(done_at), 32'd4);
        chk("single_done_count", 32'(done_cnt), 32'd1);
        chk("single_busy_after", {31'b0, busy1}, 32'd0);
        chk("single_valid_after", {31'b0, out_valid1}, 32'd0);
        chk("single_queue_left", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
